// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-level run controls and the CPU run sequencer.
// master = board/controller side, slave = cpu_run_ctrl.
`timescale 1ns/1ps
interface cpu_run_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 stop;
    logic                 step;
    logic [31:0]          pc;
    logic [31:0]          instr;
    logic [31:0]          bp_addr;
    logic                 bp_valid;
    logic                 cpu_rst;
    logic                 cpu_en;
    logic                 halted;
    logic [1:0]           halt_cause;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        output start, stop, step, pc, instr, bp_addr, bp_valid,
        input  cpu_rst, cpu_en, halted, halt_cause, state, instr_count
    );

    modport slave (
        input  start, stop, step, pc, instr, bp_addr, bp_valid,
        output cpu_rst, cpu_en, halted, halt_cause, state, instr_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle CPU: boot window, free-run, stop, single-step,
// halt-on-opcode. The PC breakpoint is compiled in only when RUN_CTRL_BREAKPOINT_EN is defined.
`timescale 1ns/1ps
module cpu_run_ctrl #(
    parameter int         BOOT_CYCLES = 2,
    parameter logic [5:0] HALT_OPCODE = 6'h3F,
    parameter int         CNT_WIDTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    cpu_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BOOT = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);

    state_t               state_reg;
    logic [BOOT_W-1:0]    boot_cnt_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [1:0]           cause_reg;
    logic                 halted_reg;

    logic op_hit;
    logic bp_hit;
    logic halt_hit;
    logic cpu_en;

    assign op_hit = (bus.instr[31:26] == HALT_OPCODE);

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic resume_first_reg;
    logic unused_instr;

    // The first cycle after a resume ignores the breakpoint so execution can leave the halted PC.
    assign bp_hit       = bus.bp_valid && (bus.pc == bus.bp_addr) && !resume_first_reg;
    assign unused_instr = ^bus.instr[25:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            resume_first_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            resume_first_reg <= 1'b0;
        end else if (state_reg == ST_HALT && bus.start) begin
            resume_first_reg <= 1'b1;
        end
    end
`else
    logic unused_inputs;

    assign bp_hit        = 1'b0;
    assign unused_inputs = ^{bus.pc, bus.bp_addr, bus.bp_valid, bus.instr[25:0]};
`endif

    assign halt_hit = op_hit || bp_hit;
    assign cpu_en   = (state_reg == ST_RUN && !halt_hit) || (state_reg == ST_STEP && !op_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            boot_cnt_reg <= '0;
            count_reg    <= '0;
            cause_reg    <= 2'b00;
            halted_reg   <= 1'b0;
        end else begin
            if (cpu_en && count_reg != {CNT_WIDTH{1'b1}}) begin
                count_reg <= count_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg    <= ST_BOOT;
                        boot_cnt_reg <= BOOT_LOAD;
                        count_reg    <= '0;
                        cause_reg    <= 2'b00;
                    end
                end
                ST_BOOT: begin
                    if (boot_cnt_reg == '0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        boot_cnt_reg <= boot_cnt_reg - 1'b1;
                    end
                end
                ST_RUN: begin
                    // The hitting instruction is suppressed; a plain stop lets the current one retire.
                    if (halt_hit) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                        cause_reg  <= op_hit ? 2'b10 : 2'b11;
                    end else if (bus.stop) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                        cause_reg  <= 2'b01;
                    end
                end
                ST_HALT: begin
                    if (bus.start) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                    end else if (bus.step) begin
                        state_reg  <= ST_STEP;
                        halted_reg <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_rst     = (state_reg == ST_IDLE) || (state_reg == ST_BOOT);
    assign bus.cpu_en      = cpu_en;
    assign bus.halted      = halted_reg;
    assign bus.halt_cause  = cause_reg;
    assign bus.state       = state_reg;
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios followed by random control traffic, all checked
// against a cycle-level reference model of the run/halt rules and a toy PC-advancing datapath.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
    localparam int          BOOT_CYCLES = 2;
    localparam int          CW          = 6;
    localparam logic [5:0]  HOP         = 6'h3F;
    localparam logic [31:0] OPI         = 32'hFC000000;
    localparam int          MAXC        = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_BOOT = 1, S_RUN = 2, S_STEP = 3, S_HALT = 4;
`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_run_ctrl_if #(.CNT_WIDTH(CW)) bus();

    cpu_run_ctrl #(
        .BOOT_CYCLES(BOOT_CYCLES),
        .HALT_OPCODE(HOP),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         m_state = S_IDLE;
    int         m_left  = 0;
    int         m_count = 0;
    logic [1:0] m_cause = 2'b00;
    bit         m_resume = 1'b0;
    bit         m_op, m_bp, m_en, m_rst;

    logic [31:0] prog [256];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v[31:26] == HOP) v[31] = 1'b0;
        return v;
    endfunction

    task automatic model_comb();
        m_op  = (bus.instr[31:26] == HOP);
        m_bp  = BP_EN && bus.bp_valid && (bus.pc == bus.bp_addr) && !m_resume;
        m_rst = (m_state == S_IDLE) || (m_state == S_BOOT);
        m_en  = (m_state == S_RUN && !(m_op || m_bp)) || (m_state == S_STEP && !m_op);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = S_IDLE; m_count = 0; m_cause = 2'b00; m_resume = 1'b0;
        end else begin
            if (m_en && m_count < MAXC) m_count++;
            case (m_state)
                S_IDLE: if (bus.start) begin
                    m_state = S_BOOT; m_left = BOOT_CYCLES; m_count = 0; m_cause = 2'b00;
                end
                S_BOOT: begin
                    m_left--;
                    if (m_left == 0) m_state = S_RUN;
                end
                S_RUN: begin
                    m_resume = 1'b0;
                    if (m_op || m_bp) begin
                        m_state = S_HALT; m_cause = m_op ? 2'b10 : 2'b11;
                    end else if (bus.stop) begin
                        m_state = S_HALT; m_cause = 2'b01;
                    end
                end
                S_HALT: begin
                    if (bus.start) begin
                        m_state = S_RUN; m_resume = 1'b1;
                    end else if (bus.step) begin
                        m_state = S_STEP;
                    end
                end
                default: m_state = S_HALT;
            endcase
        end
    endtask

    // One clock: advance model and toy datapath, then compare every output at the falling edge.
    task automatic tick();
        logic [31:0] nxt_pc;
        model_comb();
        nxt_pc = m_rst ? 32'd0 : (m_en ? bus.pc + 32'd4 : bus.pc);
        @(posedge clk);
        model_edge();
        #1;
        bus.pc    = nxt_pc;
        bus.instr = prog[nxt_pc[9:2]];
        @(negedge clk);
        cyc++;
        model_comb();
        check("state",  64'(bus.state),       64'(m_state));
        check("cpu_rst", 64'(bus.cpu_rst),    64'(m_rst));
        check("cpu_en", 64'(bus.cpu_en),      64'(m_en));
        check("halted", 64'(bus.halted),      64'(m_state == S_HALT));
        check("cause",  64'(bus.halt_cause),  64'(m_cause));
        check("count",  64'(bus.instr_count), 64'(m_count));
        $display("cyc %0d st %0d rst %b en %b halted %b cause %0d cnt %0d pc %08h",
                 cyc, bus.state, bus.cpu_rst, bus.cpu_en, bus.halted, bus.halt_cause,
                 bus.instr_count, bus.pc);
    endtask

    task automatic refresh_instr();
        bus.instr = prog[bus.pc[9:2]];
    endtask

    initial begin
        int n;
        int c0;
        logic [31:0] q;
        logic [7:0]  idx;

        for (int i = 0; i < 256; i++) prog[i] = rand_instr();
        bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
        bus.bp_addr = 32'd0; bus.bp_valid = 1'b0;
        bus.pc = 32'd0; bus.instr = prog[0];

        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        check("rst_state", 64'(bus.state), 64'(0));
        check("rst_cpu_rst", 64'(bus.cpu_rst), 64'(1));
        check("rst_count", 64'(bus.instr_count), 64'(0));

        // boot window length
        n = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        while (bus.cpu_rst && n < 20) begin n++; tick(); end
        check("boot_len", 64'(n), 64'(BOOT_CYCLES));
        check("boot_run", 64'(bus.cpu_en), 64'(1));

        // 9 plain run cycles plus the stop cycle
        repeat (9) tick();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("stop_count", 64'(bus.instr_count), 64'(10));
        check("stop_halted", 64'(bus.halted), 64'(1));
        check("stop_cause", 64'(bus.halt_cause), 64'(1));
        repeat (3) tick();
        check("stop_frozen", 64'(bus.instr_count), 64'(10));

        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1; tick(); bus.step = 1'b0;
            check("step_state", 64'(bus.state), 64'(S_STEP));
            tick();
            check("step_back", 64'(bus.state), 64'(S_HALT));
            tick();
        end
        check("step_count", 64'(bus.instr_count), 64'(13));

        // halt opcode one word past the current PC
        q = bus.pc; idx = q[9:2] + 8'd1; prog[idx] = OPI;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        check("op_en", 64'(bus.cpu_en), 64'(0));
        tick();
        check("op_cause", 64'(bus.halt_cause), 64'(2));
        check("op_count", 64'(bus.instr_count), 64'(14));
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("op_resume_en", 64'(bus.cpu_en), 64'(0));
        tick();
        check("op_rehalt", 64'(bus.halted), 64'(1));
        bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
        check("op_step_count", 64'(bus.instr_count), 64'(14));
        prog[idx] = rand_instr(); refresh_instr();

        // breakpoint two words ahead
        q = bus.pc; c0 = int'(bus.instr_count);
        bus.bp_addr = q + 32'd8; bus.bp_valid = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 10 && !bus.halted; i++) tick();
`ifdef RUN_CTRL_BREAKPOINT_EN
        check("bp_halted", 64'(bus.halted), 64'(1));
        check("bp_cause", 64'(bus.halt_cause), 64'(3));
        check("bp_count", 64'(bus.instr_count), 64'(c0 + 2));
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("bp_resume_en", 64'(bus.cpu_en), 64'(1));
        tick();
        check("bp_resume_state", 64'(bus.state), 64'(S_RUN));
        check("bp_resume_count", 64'(bus.instr_count), 64'(c0 + 3));
`else
        check("bp_ignored", 64'(bus.halted), 64'(0));
        check("bp_ignored_state", 64'(bus.state), 64'(S_RUN));
`endif
        bus.bp_valid = 1'b0;
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;

        // stop and halt opcode in the same RUN cycle
        q = bus.pc; prog[q[9:2]] = OPI; refresh_instr();
        bus.start = 1'b1; bus.stop = 1'b1; tick();
        bus.start = 1'b0; tick(); bus.stop = 1'b0;
        check("prio_cause", 64'(bus.halt_cause), 64'(2));
        prog[q[9:2]] = rand_instr(); refresh_instr();
        bus.start = 1'b1; bus.step = 1'b1; tick();
        bus.start = 1'b0; bus.step = 1'b0;
        check("prio_start", 64'(bus.state), 64'(S_RUN));
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_state", 64'(bus.state), 64'(S_IDLE));
        check("mid_rst_count", 64'(bus.instr_count), 64'(0));
        check("mid_rst_cpu_rst", 64'(bus.cpu_rst), 64'(1));

        // counter saturation
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (BOOT_CYCLES + 70) tick();
        check("sat_count", 64'(bus.instr_count), 64'(MAXC));

        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom % 200) == 0;
            bus.start = ($urandom % 8) == 0;
            bus.stop  = ($urandom % 16) == 0;
            bus.step  = ($urandom % 4) == 0;
            bus.bp_valid = $urandom % 2;
            if ($urandom % 4 == 0) bus.bp_addr = bus.pc + 32'(4 * $urandom_range(0, 3));
            if ($urandom % 40 == 0) begin
                idx = bus.pc[9:2] + 8'($urandom_range(0, 3));
                prog[idx] = OPI;
            end
            if (bus.halted && ($urandom % 8) == 0) prog[bus.pc[9:2]] = rand_instr();
            refresh_instr();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt sequencer for the single-cycle CPU datapath.
- Holds the datapath in reset while idle and releases it through a timed boot window.
- Gates architectural updates (PC load, register-file write, data-memory write, carry flop) with one enable.
- Supports free-run, stop request, single-step, halt-on-opcode and an optional PC breakpoint.
- Sits between the board-level controls and the CPU top: drives its reset and global write enable, and observes the current PC and instruction.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles cpu_rst is held after start; minimum 1. Covers the synchronous I-cache fetch of address 0.
- HALT_OPCODE, 6'h3F: instr[31:26] value treated as the HALT instruction.
- CNT_WIDTH, 32: width of instr_count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level, sampled each edge; IDLE→BOOT, HALT→RUN (resume).
- stop  in  1  level; RUN→HALT request.
- step  in  1  level; in HALT, execute exactly one instruction.
- pc  in  32  current PC from the datapath.
- instr  in  32  current instruction from the I-cache.
- bp_addr  in  32  breakpoint PC.
- bp_valid  in  1  breakpoint armed.
- cpu_rst  out  1  reset to the datapath.
- cpu_en  out  1  global architectural write enable.
- halted  out  1  state==HALT.
- halt_cause  out  2  00 none, 01 stop, 10 opcode, 11 breakpoint.
- state  out  3  IDLE=0, BOOT=1, RUN=2, STEP=3, HALT=4.
- instr_count  out  CNT_WIDTH  number of instructions executed.

## Operation
Decodes:
- op_hit = (instr[31:26]==HALT_OPCODE).
- bp_hit = bp_valid && pc==bp_addr && !resume_first.
- halt_hit = op_hit || bp_hit.

Combinational outputs:
- cpu_rst = (state==IDLE || state==BOOT).
- cpu_en = (state==RUN && !halt_hit) || (state==STEP && !op_hit).

Transitions:
- IDLE: start → BOOT. Load boot counter with BOOT_CYCLES-1, clear instr_count, clear halt_cause.
- BOOT: decrement counter each cycle; at 0 → RUN.
- RUN:
  - halt_hit → HALT; halt_cause=10 if op_hit, else 11. The hitting instruction is not executed.
  - otherwise stop → HALT with halt_cause=01. The instruction in the stop cycle is executed.
  - otherwise stay in RUN.
- HALT:
  - start → RUN, set resume_first.
  - otherwise step → STEP.
  - otherwise stay.
- STEP: unconditionally → HALT. halt_cause keeps its prior value.

resume_first:
- Set on HALT→RUN.
- Cleared after the first RUN cycle.
- Lets a resume step off the breakpointed PC.
- Not applied to op_hit: HALT opcode is terminal; resume re-halts immediately, step is a no-op.

instr_count:
- +1 on every edge where cpu_en=1.
- Saturates at all-ones.
- Cleared on IDLE→BOOT and by rst.

Priorities:
- rst over everything.
- RUN: halt_hit > stop.
- HALT: start > step.
- start in RUN/BOOT/STEP is ignored.
- stop/step in IDLE/BOOT are ignored.

## Timing
Reset values: state=IDLE, cpu_rst=1, cpu_en=0, halted=0, halt_cause=00, instr_count=0, resume_first=0.

Latency:
- start sampled at edge N: cpu_rst=1 through cycle N+BOOT_CYCLES; RUN (cpu_en=1) from cycle N+BOOT_CYCLES+1.
- stop sampled high at edge N in RUN: cycle before N executes; halted=1 from N.
- step: exactly one cpu_en=1 cycle, then halted=1 again. A held step repeats every 2 cycles.

Other rules:
- rst asserted mid-RUN/STEP: cpu_en drops combinationally only after the next edge (state→IDLE). Datapath reset follows from cpu_rst the same edge.
- All outputs except cpu_rst/cpu_en are registered.

## Configuration
RUN_CTRL_BREAKPOINT_EN:
- Defined: breakpoint compare compiled in as described.
- Undefined: bp_hit tied 0, bp_addr/bp_valid ports remain but are ignored, halt_cause never 11, no resume_first logic.

## Test plan
- Boot: rst, then start pulse at edge 3, BOOT_CYCLES=2. Required: cpu_rst=1 through cycle 5, cpu_en=1 from cycle 6, state 0→1→1→2.
- Stop: run 10 cycles, stop for 1 cycle. Required: instr_count=10 including the stop cycle; halted=1, halt_cause=01; count frozen while halted.
- Single-step: from HALT, pulse step three times with gaps. Required: three single cpu_en cycles, count +3, state 4→3→4 each time.
- Halt opcode: instr=0xFC000000 during RUN. Required: cpu_en=0 that cycle, HALT with cause 10. Then start → RUN, re-halts next edge; step → count unchanged.
- Breakpoint (macro defined): bp_addr=0x14, bp_valid=1, PC reaches 0x14. Required: halt, cause 11, PC held at 0x14; start resumes and executes 0x14 without re-halting. Macro undefined: no halt.
- Priority and reset: stop+halt opcode in the same cycle gives cause 10. start+step in HALT gives RUN. rst asserted mid-RUN gives IDLE, count 0, cpu_rst=1 next cycle.
